// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and NZCV bit-position definitions for the iterative ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_ORR  = 3'b011,
        OP_EOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add multiplier core: one multiplier bit per cycle, WIDTH cycles after load.
// product is the accumulator value after the current iteration; no backpressure, free-runs after load.
module mul_shift_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             last
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;

    // Exposing the post-iteration sum lets the owner capture the final product on the last edge.
    assign product = acc + (b_sh[0] ? a_sh : '0);
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
        end else if (load) begin
            acc  <= '0;
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
        end else begin
            acc  <= product;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU feeding the NZCV flag register: 1-cycle logic/arith ops, WIDTH+1-cycle MUL.
// start is accepted whenever busy=0 (including the done cycle); requests while busy are dropped.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic             flag_we
);
    state_t           state;
    logic             set_flags_q;
    logic             accept;
    logic             mul_load;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;
    logic             alu_valid;
    logic [3:0]       alu_flags;
    logic [3:0]       mul_flags;

    assign accept   = start && (state != RUN);
    assign mul_load = accept && (op == OP_MUL);

    mul_shift_add #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .product (mul_product),
        .last    (mul_last)
    );

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        alu_r     = '0;
        alu_c     = flags_in[FLAG_C];
        alu_v     = flags_in[FLAG_V];
        alu_valid = 1'b1;
        case (op_t'(op))
            OP_ADD: begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r = diff[WIDTH-1:0];
                alu_c = ~diff[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_r = a & b;
            OP_ORR:  alu_r = a | b;
            OP_EOR:  alu_r = a ^ b;
            default: alu_valid = 1'b0;
        endcase

        // Reserved ops pass the current flags through untouched.
        alu_flags = flags_in;
        if (alu_valid) begin
            alu_flags[FLAG_N] = alu_r[WIDTH-1];
            alu_flags[FLAG_Z] = ~|alu_r;
            alu_flags[FLAG_C] = alu_c;
            alu_flags[FLAG_V] = alu_v;
        end

        mul_flags         = flags_in;
        mul_flags[FLAG_N] = mul_product[WIDTH-1];
        mul_flags[FLAG_Z] = ~|mul_product;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            set_flags_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            flag_we     <= 1'b0;
            result      <= '0;
            flags_out   <= '0;
        end else begin
            done    <= 1'b0;
            flag_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        set_flags_q <= set_flags;
                        if (op == OP_MUL) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            flag_we   <= set_flags && alu_valid;
                            result    <= alu_r;
                            flags_out <= alu_flags;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (mul_last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        flag_we   <= set_flags_q;
                        result    <= mul_product;
                        flags_out <= mul_flags;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed scenarios plus randomized traffic against a behavioural model.
module tb_iter_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         set_flags = 1'b0;
    logic [3:0]   flags_in = 4'd0;
    logic         busy, done, flag_we;
    logic [W-1:0] result;
    logic [3:0]   flags_out;

    int checks = 0;
    int errors = 0;

    iter_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .set_flags (set_flags),
        .flags_in  (flags_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags_out (flags_out),
        .flag_we   (flag_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {result, N, Z, C, V} computed with ordinary integer arithmetic.
    function automatic logic [11:0] model(input int o, input int x, input int y, input logic [3:0] fi);
        int  r, sx, sy, s;
        logic c, v;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        c = fi[1];
        v = fi[0];
        case (o)
            0: begin r = x + y; c = (r > 255); s = sx + sy; v = (s > 127) || (s < -128); r = r % 256; end
            1: begin r = x - y; c = (x >= y);  s = sx - sy; v = (s > 127) || (s < -128); r = (r + 256) % 256; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (x * y) % 256;
            default: return {8'h00, fi};
        endcase
        return {8'(r), (r >= 128), (r == 0), c, v};
    endfunction

    // Behavioural reference: a countdown of remaining multiply cycles stands in for the whole sequencer.
    int           m_left;
    logic [7:0]   m_a, m_b;
    logic         m_sf;
    logic         e_busy, e_done, e_we;
    logic [7:0]   e_res;
    logic [3:0]   e_flg;
    logic [11:0]  m_out;

    assign m_out = (m_left > 0) ? model(5, int'(m_a), int'(m_b), flags_in)
                                : model(int'(op), int'(a), int'(b), flags_in);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0; m_a <= '0; m_b <= '0; m_sf <= 1'b0;
            e_busy <= 1'b0; e_done <= 1'b0; e_we <= 1'b0; e_res <= '0; e_flg <= '0;
        end else begin
            e_done <= 1'b0;
            e_we   <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                e_busy <= (m_left > 1);
                if (m_left == 1) begin
                    e_done <= 1'b1; e_we <= m_sf;
                    e_res <= m_out[11:4]; e_flg <= m_out[3:0];
                end
            end else if (start) begin
                if (op == 3'd5) begin
                    m_left <= W; e_busy <= 1'b1; m_a <= a; m_b <= b; m_sf <= set_flags;
                end else begin
                    e_done <= 1'b1; e_we <= set_flags && (op < 3'd6);
                    e_res <= m_out[11:4]; e_flg <= m_out[3:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("flag_we", 32'(flag_we), 32'(e_we));
        chk("result", 32'(result), 32'(e_res));
        chk("flags_out", 32'(flags_out), 32'(e_flg));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic sf, input logic [3:0] fi);
        start = 1'b1; op = o; a = x; b = y; set_flags = sf; flags_in = fi;
        step();
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat = 1;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (busy) nbusy++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout after %0d cycles", lat);
        end
    endtask

    initial begin
        int lat, nb, seen;
        chk("pin_add", 32'(model(0, 8'h7F, 8'h01, 4'b0000)), 32'({8'h80, 4'b1001}));
        chk("pin_sub", 32'(model(1, 8'h03, 8'h05, 4'b0000)), 32'({8'hFE, 4'b1000}));
        chk("pin_mul", 32'(model(5, 8'h0C, 8'h0B, 4'b0011)), 32'({8'h84, 4'b1011}));
        chk("pin_rsv", 32'(model(6, 8'h12, 8'h34, 4'b1010)), 32'({8'h00, 4'b1010}));

        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'(flags_out), 0);
        reset = 1'b0;
        step();

        issue(3'd0, 8'h7F, 8'h01, 1'b1, 4'b0000);
        wait_done(lat, nb);
        chk("add_lat", 32'(lat), 1);
        chk("add_res", 32'(result), 32'h80);
        chk("add_flg", 32'(flags_out), 32'b1001);
        chk("add_we", 32'(flag_we), 1);
        step();

        issue(3'd1, 8'h05, 8'h05, 1'b1, 4'b0000);
        wait_done(lat, nb);
        chk("sub_eq_res", 32'(result), 32'h00);
        chk("sub_eq_flg", 32'(flags_out), 32'b0110);
        step();
        issue(3'd1, 8'h03, 8'h05, 1'b1, 4'b0000);
        wait_done(lat, nb);
        chk("sub_lt_res", 32'(result), 32'hFE);
        chk("sub_lt_flg", 32'(flags_out), 32'b1000);
        step();

        issue(3'd5, 8'h0C, 8'h0B, 1'b1, 4'b0011);
        wait_done(lat, nb);
        chk("mul_lat", 32'(lat), 9);
        chk("mul_busy_cycles", 32'(nb), 8);
        chk("mul_res", 32'(result), 32'h84);
        chk("mul_flg", 32'(flags_out), 32'b1011);
        chk("mul_we", 32'(flag_we), 1);
        step();

        // Start during RUN must be dropped, then a start held in the done cycle is taken back-to-back.
        issue(3'd5, 8'h0C, 8'h0B, 1'b1, 4'b0011);
        step(); step();
        start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
        step();
        start = 1'b0;
        wait_done(lat, nb);
        chk("mul_ign_res", 32'(result), 32'h84);
        issue(3'd0, 8'h10, 8'h20, 1'b1, 4'b0000);
        chk("b2b_done", 32'(done), 1);
        chk("b2b_res", 32'(result), 32'h30);
        chk("b2b_flg", 32'(flags_out), 32'b0000);
        step();

        issue(3'd5, 8'hFF, 8'hFF, 1'b1, 4'b0000);
        step(); step(); step();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_flags", 32'(flags_out), 0);
        chk("mid_rst_we", 32'(flag_we), 0);
        step();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || flag_we) seen++;
        end
        chk("mid_rst_no_done", 32'(seen), 0);
        issue(3'd0, 8'h01, 8'h01, 1'b1, 4'b0000);
        wait_done(lat, nb);
        chk("post_rst_lat", 32'(lat), 1);
        chk("post_rst_res", 32'(result), 32'h02);
        step();

        issue(3'd2, 8'hF0, 8'h0F, 1'b0, 4'b0010);
        wait_done(lat, nb);
        chk("and_res", 32'(result), 32'h00);
        chk("and_flg", 32'(flags_out), 32'b0110);
        chk("and_we", 32'(flag_we), 0);
        step();
        issue(3'd6, 8'h55, 8'hAA, 1'b1, 4'b1010);
        wait_done(lat, nb);
        chk("rsv_res", 32'(result), 32'h00);
        chk("rsv_flg", 32'(flags_out), 32'b1010);
        chk("rsv_we", 32'(flag_we), 0);
        step();

        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 99) < 45);
            op        = 3'($urandom_range(0, 7));
            a         = 8'($urandom);
            b         = 8'($urandom);
            set_flags = 1'($urandom);
            flags_in  = 4'($urandom);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Multi-cycle ALU that sits directly upstream of the 4-bit NZCV flag register and the 1-bit flag flops.
- Accepts one operation per start/busy handshake and produces a registered result with a one-cycle done pulse.
- Also produces the new 4-bit NZCV vector and a one-cycle write-enable; these drive the flag register's data and enable inputs.
- Single-cycle logic/arithmetic ops; MUL is iterative shift-add.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110/111 reserved
- a  in  WIDTH  operand A, sampled on the accepting edge
- b  in  WIDTH  operand B, sampled on the accepting edge
- set_flags  in  1  sampled on the accepting edge; enables flag_we for this op
- flags_in  in  4  current NZCV from the flag register ([3]N [2]Z [1]C [0]V)
- busy  out  1  operation in progress; start is ignored while high
- done  out  1  one-cycle pulse; result and flags_out valid
- result  out  WIDTH  registered result, held until the next done
- flags_out  out  4  new NZCV, held with result
- flag_we  out  1  one-cycle pulse coincident with done when set_flags was latched

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - busy=0, done=0, flag_we=0, result=0, flags_out=0.
  - Any operation in flight is abandoned with no done or flag_we.
- States: IDLE, RUN, DONE.
  - IDLE: busy=0. start=1 latches op, a, b and set_flags. Non-MUL ops go to DONE on the next edge; MUL goes to RUN with counter=0.
  - RUN: busy=1. One multiplier bit per cycle: if b_sh[0], acc += a_sh; then a_sh <<= 1, b_sh >>= 1. After WIDTH iterations, go to DONE.
  - DONE: done=1 for exactly one cycle, and flag_we=set_flags_latched. busy=0, so start in this cycle is accepted (back-to-back). Without start, go to IDLE.
- Latency:
  - Non-MUL ops: done is asserted 1 cycle after the accepting edge.
  - MUL: done is asserted WIDTH+1 cycles after the accepting edge.
- Start while busy=1 is ignored entirely; no queuing.
- Operands are captured at acceptance; later changes on a/b are ignored.
- flags_in is sampled in the last compute cycle: the accepting cycle for single-cycle ops, the final RUN cycle for MUL.
- Arithmetic (WIDTH bits, wrap-around):
  - ADD: {C,r} = a+b. V = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB: r = a−b. C = (a>=b) unsigned, i.e. no borrow. V = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - AND/ORR/EOR: bitwise. C and V are copied from flags_in.
  - MUL: result = low WIDTH bits of a*b; upper bits are discarded. C and V are copied from flags_in.
  - All ops: N = r[msb]; Z = (r == 0).
- Reserved op: completes in 1 cycle with result=0 and flags_out=flags_in. flag_we is forced to 0.
- result and flags_out change only on the edge that enters DONE.

Decomposition:
- Shared package alu_pkg:
  - op_t enum (3 bits, encodings above)
  - state_t enum {IDLE, RUN, DONE}
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module mul_shift_add #(WIDTH):
  - Inputs: clk, reset, load, a, b.
  - Outputs: product (WIDTH bits), last.
  - Holds the iteration counter and the shift registers.
- iter_alu owns the FSM, the single-cycle datapath and the flag logic.

Test Plan (WIDTH=8):
- ADD a=0x7F, b=0x01, set_flags=1 -> done 1 cycle after start; result=0x80, flags_out=1001, flag_we pulses with done.
- SUB a=0x05, b=0x05, set_flags=1 -> result=0x00, flags_out=0110; SUB a=0x03, b=0x05 -> result=0xFE, flags_out=1000.
- MUL a=0x0C, b=0x0B, flags_in=0011, set_flags=1 -> busy for 8 cycles, done 9 cycles after start; result=0x84, flags_out=1011.
- start pulsed during MUL RUN with op=ADD -> ignored; exactly one done (MUL result). Then start held in the DONE cycle -> next op accepted and done exactly 1 cycle later.
- reset asserted mid-MUL (cycle 4) -> outputs 0 immediately, state IDLE, no done/flag_we. A new ADD afterward completes normally.
- AND a=0xF0, b=0x0F, set_flags=0, flags_in=0010 -> result=0x00, flags_out=0110, flag_we stays 0. Reserved op 110 -> result=0, flag_we=0.
